// File: rtl/lc_const_stream_rom.sv
// Read-only lifecycle constant store. A single request over a valid/ready address
// channel streams one WIDTH-bit entry out as BUS_W-wide beats, LSB chunk first.
module lc_const_stream_rom #(
   parameter int                      WIDTH     = 256,
   parameter int                      LENGTH    = 6,
   parameter int                      BUS_W     = 32,
   parameter logic [LENGTH*WIDTH-1:0] INIT      = '0,
   parameter logic [LENGTH-1:0]       LOCK_MASK = '0,
   localparam int                     ADDR_W    = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              unlock,
   input  logic              kill,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BUS_W-1:0]  out_data,
   output logic              out_last,
   output logic              out_err,
   output logic              busy,
   output logic              killed
);

   localparam int BEATS = WIDTH / BUS_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, STREAM, ERRBEAT} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [BUS_W-1:0]   out_data_q, out_data_d;
   logic               out_last_q, out_last_d;
   logic               out_err_q, out_err_d;
   logic               busy_q, busy_d;
   logic               killed_q, killed_d;
   logic               req_ready_q, req_ready_d;

   logic accept, beat_xfer, addr_oob, locked, bad_req;

   // Out-of-range indices return zero so the lookup is total.
   function automatic logic [BUS_W-1:0] rom_beat(input logic [ADDR_W-1:0] a,
                                                 input logic [CNT_W-1:0]  k);
      rom_beat = '0;
      for (int i = 0; i < LENGTH; i++) begin
         if (int'(a) == i) rom_beat = INIT[i*WIDTH + int'(k)*BUS_W +: BUS_W];
      end
   endfunction

   always_comb begin
      locked = 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
         if (int'(req_addr) == i) locked = LOCK_MASK[i];
      end
   end

   assign addr_oob  = int'(req_addr) >= LENGTH;
   assign accept    = req_valid & req_ready_q;
   assign beat_xfer = out_valid_q & out_ready;
   assign bad_req   = addr_oob | killed_q | kill | (locked & ~unlock);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_err_d   = out_err_q;
      killed_d    = killed_q | kill;

      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d      = req_addr;
               cnt_d       = '0;
               out_valid_d = 1'b1;
               if (bad_req) begin
                  state_d    = ERRBEAT;
                  out_data_d = '0;
                  out_err_d  = 1'b1;
                  out_last_d = 1'b1;
               end else begin
                  state_d    = STREAM;
                  out_data_d = rom_beat(req_addr, '0);
                  out_err_d  = 1'b0;
                  out_last_d = (BEATS == 1);
               end
            end
         end
         STREAM: begin
            if (beat_xfer) begin
               if (out_last_q) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
                  out_data_d  = '0;
                  out_last_d  = 1'b0;
                  out_err_d   = 1'b0;
               end else begin
                  // A kill keeps the beat count but blanks every beat still to come.
                  cnt_d      = cnt_q + 1'b1;
                  out_err_d  = killed_d;
                  out_data_d = killed_d ? '0 : rom_beat(addr_q, cnt_d);
                  out_last_d = (int'(cnt_d) == BEATS - 1);
               end
            end
         end
         ERRBEAT: begin
            if (beat_xfer) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               out_data_d  = '0;
               out_last_d  = 1'b0;
               out_err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         killed_q    <= 1'b0;
         req_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_err_q   <= out_err_d;
         busy_q      <= busy_d;
         killed_q    <= killed_d;
         req_ready_q <= req_ready_d;
      end
   end

   assign req_ready = req_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_err   = out_err_q;
   assign busy      = busy_q;
   assign killed    = killed_q;

endmodule

// File: tb/tb_lc_const_stream_rom.sv
// Bench for lc_const_stream_rom: vector table, randomized back-pressure against an
// entry/beat-list reference model, and directed kill / reset-abort sequences.
module tb_lc_const_stream_rom;

   localparam int WIDTH = 256;
   localparam int LENGTH = 6;
   localparam int BUS_W = 32;
   localparam int BEATS = WIDTH / BUS_W;
   localparam logic [LENGTH-1:0] LOCK = 6'b000010;

   localparam logic [255:0] E0 = 256'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_11112222_33334444_55556666_77778888;
   localparam logic [255:0] E1 = {32'h33a344a3, 32'h1b2c3d4e, 32'h5f607182, 32'h93a4b5c6,
                                  32'hd7e8f901, 32'h12233445, 32'h56677889, 32'hea56a24a};
   localparam logic [255:0] E2 = 256'hcafef00d_deadbeef_01020304_05060708_090a0b0c_0d0e0f10_a5a5a5a5_5a5a5a5a;
   localparam logic [255:0] E3 = 256'h13579bdf_2468ace0_fedcba98_76543210_0badc0de_feedface_c001d00d_b16b00b5;
   localparam logic [255:0] E4 = 256'h00000001_00000002_00000004_00000008_00000010_00000020_00000040_00000080;
   localparam logic [255:0] E5 = 256'hffffffff_eeeeeeee_dddddddd_cccccccc_bbbbbbbb_aaaaaaaa_99999999_88888888;
   localparam logic [LENGTH*WIDTH-1:0] INIT_V = {E5, E4, E3, E2, E1, E0};

   logic              clk = 1'b0;
   logic              rst, req_valid, unlock, kill, out_ready;
   logic [2:0]        req_addr;
   logic              req_ready, out_valid, out_last, out_err, busy, killed;
   logic [BUS_W-1:0]  out_data;

   int checks = 0;
   int failures = 0;
   bit m_killed = 1'b0;

   lc_const_stream_rom #(
      .WIDTH(WIDTH), .LENGTH(LENGTH), .BUS_W(BUS_W), .INIT(INIT_V), .LOCK_MASK(LOCK)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .unlock(unlock), .kill(kill), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .out_err(out_err), .busy(busy), .killed(killed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: the response is either one zero error beat or the entry sliced LSB first.
   task automatic model(input int addr, input bit unl, output logic [31:0] q[$], output bit err);
      logic [255:0] e;
      q = {};
      err = (addr >= LENGTH) || m_killed || ((((LOCK >> addr) & 6'd1) != 0) && !unl);
      if (err) q.push_back(32'h0);
      else begin
         e = 256'(INIT_V >> (addr * WIDTH));
         for (int k = 0; k < BEATS; k++) q.push_back(e[k*BUS_W +: BUS_W]);
      end
   endtask

   task automatic run_resp(input int addr, input bit unl, input bit rnd, input string nm,
                           output logic [31:0] d0, output logic [31:0] dl,
                           output bit e0, output int nb);
      logic [31:0] q[$];
      logic [31:0] exp_d;
      bit err;
      int idx, cyc;
      model(addr, unl, q, err);
      req_addr = 3'(addr); unlock = unl; req_valid = 1'b1; out_ready = 1'b0; kill = 1'b0;
      cyc = 0;
      while (!req_ready && cyc < 20) begin tick; cyc++; end
      chk({nm, "_req_ready"}, req_ready, 1);
      tick;
      req_valid = 1'b0;
      unlock = ~unl;
      chk({nm, "_latency"}, out_valid, 1);
      d0 = out_data; e0 = out_err; dl = '0; nb = 0; idx = 0; cyc = 0;
      while (out_valid && cyc < 200) begin
         exp_d = (idx < q.size()) ? q[idx] : 32'hdeadbeef;
         chk({nm, "_data"}, out_data, exp_d);
         chk({nm, "_err"}, out_err, err);
         chk({nm, "_last"}, out_last, (idx == q.size() - 1));
         chk({nm, "_busy"}, busy, 1);
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_ready) begin dl = out_data; nb++; idx++; end
         tick;
         cyc++;
      end
      out_ready = 1'b0;
      chk({nm, "_nbeats"}, nb, q.size());
      chk({nm, "_ready_after"}, req_ready, 1);
      chk({nm, "_idle_busy"}, busy, 0);
   endtask

   typedef struct {
      int          addr;
      bit          unl;
      bit          exp_err;
      int          exp_nb;
      logic [31:0] exp_b0;
      logic [31:0] exp_bl;
   } vec_t;

   initial begin
      vec_t vt[$];
      logic [31:0] d0, dl;
      bit e0;
      int nb;

      vt = '{
         '{1, 1'b1, 1'b0, 8, 32'hea56a24a, 32'h33a344a3},
         '{6, 1'b1, 1'b1, 1, 32'h0, 32'h0},
         '{7, 1'b0, 1'b1, 1, 32'h0, 32'h0},
         '{1, 1'b0, 1'b1, 1, 32'h0, 32'h0},
         '{0, 1'b0, 1'b0, 8, 32'h77778888, 32'h0f1e2d3c},
         '{5, 1'b0, 1'b0, 8, 32'h88888888, 32'hffffffff},
         '{3, 1'b1, 1'b0, 8, 32'hb16b00b5, 32'h13579bdf}
      };

      rst = 1'b1; req_valid = 1'b0; req_addr = '0; unlock = 1'b0; kill = 1'b0; out_ready = 1'b0;
      tick; tick;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_killed", killed, 0);
      chk("rst_req_ready", req_ready, 0);
      rst = 1'b0;
      tick;
      chk("post_rst_req_ready", req_ready, 1);

      foreach (vt[i]) begin
         run_resp(vt[i].addr, vt[i].unl, 1'b0, $sformatf("vec%0d", i), d0, dl, e0, nb);
         chk($sformatf("vec%0d_tab_err", i), e0, vt[i].exp_err);
         chk($sformatf("vec%0d_tab_nb", i), nb, vt[i].exp_nb);
         chk($sformatf("vec%0d_tab_b0", i), d0, vt[i].exp_b0);
         chk($sformatf("vec%0d_tab_blast", i), dl, vt[i].exp_bl);
      end

      // Back-pressure: stall three cycles on beat 2.
      req_addr = 3'd1; unlock = 1'b1; req_valid = 1'b1; out_ready = 1'b1;
      tick;
      req_valid = 1'b0;
      nb = 0;
      for (int b = 0; b < 2; b++) begin tick; nb++; end
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         chk("stall_data", out_data, E1[2*BUS_W +: BUS_W]);
         chk("stall_last", out_last, 0);
         chk("stall_valid", out_valid, 1);
         tick;
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && out_valid; c++) begin
         if (out_last) chk("stall_last_data", out_data, E1[7*BUS_W +: BUS_W]);
         tick; nb++;
      end
      out_ready = 1'b0;
      chk("stall_total_beats", nb, BEATS);

      for (int r = 0; r < 30; r++)
         run_resp(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1, "rnd", d0, dl, e0, nb);

      // Kill raised while beat 3 is presented.
      req_addr = 3'd0; unlock = 1'b0; req_valid = 1'b1; out_ready = 1'b1;
      tick;
      req_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         chk("kill_pre_data", out_data, E0[b*BUS_W +: BUS_W]);
         chk("kill_pre_err", out_err, 0);
         if (b == 3) kill = 1'b1;
         tick;
      end
      kill = 1'b0;
      m_killed = 1'b1;
      chk("kill_sticky", killed, 1);
      for (int b = 4; b < BEATS; b++) begin
         chk("kill_post_valid", out_valid, 1);
         chk("kill_post_data", out_data, 0);
         chk("kill_post_err", out_err, 1);
         chk("kill_post_last", out_last, (b == BEATS - 1));
         tick;
      end
      out_ready = 1'b0;
      chk("kill_done_valid", out_valid, 0);
      run_resp(2, 1'b1, 1'b0, "killed_req", d0, dl, e0, nb);
      chk("killed_req_err", e0, 1);
      chk("killed_req_nb", nb, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      m_killed = 1'b0;
      chk("rst_clears_killed", killed, 0);
      tick;
      run_resp(2, 1'b0, 1'b0, "after_rst", d0, dl, e0, nb);
      chk("after_rst_err", e0, 0);
      chk("after_rst_b0", d0, E2[BUS_W-1:0]);

      // Reset while beat 5 is presented.
      req_addr = 3'd1; unlock = 1'b1; req_valid = 1'b1; out_ready = 1'b1;
      tick;
      req_valid = 1'b0;
      for (int b = 0; b < 5; b++) tick;
      chk("abort_beat5", out_data, E1[5*BUS_W +: BUS_W]);
      rst = 1'b1;
      tick;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_req_ready", req_ready, 0);
      rst = 1'b0;
      tick;
      chk("abort_release_ready", req_ready, 1);
      chk("abort_no_beats", out_valid, 0);
      out_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
